jk_bank_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit bank of JK flip-flops between NREQ requesters. Each requester posts an opcode (hold/reset/set/toggle) and a bit mask. The arbiter grants one requester at a time and drives the bank's J/K vectors for exactly one clock per grant, then returns them to hold for one recovery cycle. It sits between the control logic and the JK register bank, which is clocked on the same CLK.

---
 rtl/jk_bank_arbiter.sv | 143 ++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbiter sharing one JK flip-flop bank between NREQ requesters
//
// Ports:
//   CLK     system clock, rising edge
//   RST_n   asynchronous active-low reset
//   req     per-requester request, held until the requester sees its gnt bit
//   op      2-bit opcode per requester (00 hold, 01 reset, 10 set, 11 toggle)
//   mask    WIDTH-bit bit mask per requester
//   gnt     one-hot grant pulse, one cycle wide, aligned with J/K
//   J, K    registered drive to the JK bank, nonzero only in the grant cycle
//   busy    high while the sequencer is not idle
//   op_cnt  count of completed grants, wraps at 16 bits
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   mask,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        J,
  output logic [WIDTH-1:0]        K,
  output logic                    busy,
  output logic [15:0]             op_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  j_q, j_d;
  logic [WIDTH-1:0]  k_q, k_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW:0]       cand_sum;
  logic [PW-1:0]     cand;
  logic [1:0]        win_op;
  logic [WIDTH-1:0]  win_mask;
  logic [PW-1:0]     win_next;

  // Rotating priority search: visit ptr, ptr+1, ... modulo NREQ and keep the
  // first requester found. One extra bit on the sum lets the wrap be a plain
  // subtract, which also works when NREQ is not a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int s = 0; s < NREQ; s++) begin
      cand_sum = {1'b0, ptr_q} + (PW+1)'(s);
      if (cand_sum >= (PW+1)'(NREQ)) begin
        cand_sum = cand_sum - (PW+1)'(NREQ);
      end
      cand = cand_sum[PW-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Command of the winner.
  always_comb begin
    win_op   = '0;
    win_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_op   = op[2*i +: 2];
        win_mask = mask[WIDTH*i +: WIDTH];
      end
    end
  end

  assign win_next = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    j_d     = '0;
    k_d     = '0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RECOVER: begin
        if (win_found) begin
          state_d = ISSUE;
          ptr_d   = win_next;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          // op[1] selects J (set half), op[0] selects K (reset half);
          // both together give toggle, neither gives hold.
          j_d     = win_mask & {WIDTH{win_op[1]}};
          k_d     = win_mask & {WIDTH{win_op[0]}};
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // The command has been presented for its one cycle; count it as done.
        state_d = RECOVER;
        cnt_d   = cnt_q + 16'd1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign J      = j_q;
  assign K      = k_q;
  assign busy   = (state_q != IDLE);
  assign op_cnt = cnt_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - self-checking bench for jk_bank_arbiter
module tb_jk_bank_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic                  CLK = 1'b0;
  logic                  RST_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [2*NREQ-1:0]     op = '0;
  logic [WIDTH*NREQ-1:0] mask = '0;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      J;
  logic [WIDTH-1:0]      K;
  logic                  busy;
  logic [15:0]           op_cnt;

  int checks   = 0;
  int failures = 0;

  jk_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .req    (req),
    .op     (op),
    .mask   (mask),
    .gnt    (gnt),
    .J      (J),
    .K      (K),
    .busy   (busy),
    .op_cnt (op_cnt)
  );

  always #5 CLK = ~CLK;

  // The JK bank driven by the arbiter; not affected by the arbiter's reset.
  logic [WIDTH-1:0] bank = '0;
  always @(posedge CLK) bank <= (J & ~bank) | (~K & bank);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [7:0] ej,
                         input logic [7:0] ek, input logic eb, input logic [15:0] ec);
    chk({tag, ".gnt"},    32'(gnt),    32'(eg));
    chk({tag, ".J"},      32'(J),      32'(ej));
    chk({tag, ".K"},      32'(K),      32'(ek));
    chk({tag, ".busy"},   32'(busy),   32'(eb));
    chk({tag, ".op_cnt"}, 32'(op_cnt), 32'(ec));
  endtask

  // Reference model: a grant can happen in a cycle only if the previous cycle
  // carried no grant; a grant is counted in the cycle after it; busy covers
  // a grant cycle and the cycle following it.
  int              m_ptr;
  int              m_cur;
  logic [7:0]      m_j, m_k, m_bank;
  logic [15:0]     m_cnt;
  logic            m_busy;

  task automatic model_reset();
    m_ptr = 0; m_cur = -1; m_j = '0; m_k = '0; m_cnt = '0; m_busy = 1'b0;
  endtask

  task automatic model_step();
    int prev;
    int w;
    bit found;
    logic [1:0] mo;
    logic [7:0] mm;
    m_bank = (m_j & ~m_bank) | (~m_k & m_bank);
    prev = m_cur;
    if (prev >= 0) m_cnt = m_cnt + 16'd1;
    m_cur = -1; m_j = '0; m_k = '0;
    if (prev < 0 && req != '0) begin
      found = 0;
      w = 0;
      for (int s = 0; s < NREQ; s++) begin
        if (!found && req[(m_ptr + s) % NREQ]) begin
          found = 1;
          w = (m_ptr + s) % NREQ;
        end
      end
      m_cur = w;
      m_ptr = (w + 1) % NREQ;
      mo = op[2*w +: 2];
      mm = mask[WIDTH*w +: WIDTH];
      case (mo)
        2'b01: m_k = mm;
        2'b10: m_j = mm;
        2'b11: begin m_j = mm; m_k = mm; end
        default: ;
      endcase
    end
    m_busy = (m_cur >= 0) || (prev >= 0);
  endtask

  typedef struct packed {
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] mask;
    logic [3:0]  gnt;
    logic [7:0]  j;
    logic [7:0]  k;
    logic        busy;
    logic [15:0] cnt;
    logic [7:0]  bank;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] eg;
    // rows: inputs for one cycle, then outputs expected after the following edge
    tbl[0]  = '{4'b0001, 8'h02, 32'h0000_000F, 4'b0001, 8'h0F, 8'h00, 1'b1, 16'd0, 8'h00};
    tbl[1]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 8'h00, 8'h00, 1'b1, 16'd1, 8'h0F};
    tbl[2]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 8'h00, 8'h00, 1'b0, 16'd1, 8'h0F};
    tbl[3]  = '{4'b0010, 8'h0C, 32'h0000_FF00, 4'b0010, 8'hFF, 8'hFF, 1'b1, 16'd1, 8'h0F};
    tbl[4]  = '{4'b0010, 8'h04, 32'h0000_F000, 4'b0000, 8'h00, 8'h00, 1'b1, 16'd2, 8'hF0};
    tbl[5]  = '{4'b0010, 8'h04, 32'h0000_F000, 4'b0010, 8'h00, 8'hF0, 1'b1, 16'd2, 8'hF0};
    tbl[6]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 8'h00, 8'h00, 1'b1, 16'd3, 8'h00};
    tbl[7]  = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 8'h00, 8'h00, 1'b0, 16'd3, 8'h00};
    tbl[8]  = '{4'b1111, 8'h00, 32'h0000_0000, 4'b0100, 8'h00, 8'h00, 1'b1, 16'd3, 8'h00};
    tbl[9]  = '{4'b1011, 8'h00, 32'h0000_0000, 4'b0000, 8'h00, 8'h00, 1'b1, 16'd4, 8'h00};
    tbl[10] = '{4'b1011, 8'h00, 32'h0000_0000, 4'b1000, 8'h00, 8'h00, 1'b1, 16'd4, 8'h00};
    tbl[11] = '{4'b0011, 8'h00, 32'h0000_0000, 4'b0000, 8'h00, 8'h00, 1'b1, 16'd5, 8'h00};
    tbl[12] = '{4'b0011, 8'h00, 32'h0000_0000, 4'b0001, 8'h00, 8'h00, 1'b1, 16'd5, 8'h00};
    tbl[13] = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 8'h00, 8'h00, 1'b1, 16'd6, 8'h00};
    tbl[14] = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 8'h00, 8'h00, 1'b0, 16'd6, 8'h00};

    // Reset then idle
    @(negedge CLK);
    chk_out("reset", 4'b0, 8'h00, 8'h00, 1'b0, 16'd0);
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk_out("idle", 4'b0, 8'h00, 8'h00, 1'b0, 16'd0);
    end

    // Directed table: single set, toggle then reset, ptr-resolved contention
    for (int r = 0; r < 15; r++) begin
      req  = tbl[r].req;
      op   = tbl[r].op;
      mask = tbl[r].mask;
      @(negedge CLK);
      chk_out($sformatf("tbl%0d", r), tbl[r].gnt, tbl[r].j, tbl[r].k, tbl[r].busy, tbl[r].cnt);
      chk($sformatf("tbl%0d.bank", r), 32'(bank), 32'(tbl[r].bank));
    end

    // Round-robin under full load, then reset during the second grant to 2
    RST_n = 1'b0;
    req = '0; op = '0; mask = '0;
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
    req  = 4'b1111;
    op   = 8'h30;
    mask = 32'h00FF_0000;
    for (int c = 1; c <= 13; c++) begin
      @(negedge CLK);
      eg = (c % 2 == 1) ? 4'(1 << (((c - 1) / 2) % 4)) : 4'b0000;
      chk_out($sformatf("rr%0d", c), eg, (eg == 4'b0100) ? 8'hFF : 8'h00,
              (eg == 4'b0100) ? 8'hFF : 8'h00, 1'b1, 16'(c / 2));
    end
    RST_n = 1'b0;
    #1;
    chk_out("midrst", 4'b0, 8'h00, 8'h00, 1'b0, 16'd0);
    @(posedge CLK);
    #1;
    chk("midrst.bank", 32'(bank), 32'h0000_00FF);
    @(negedge CLK);
    req = 4'b1010; op = '0; mask = '0;
    RST_n = 1'b1;
    @(negedge CLK);
    chk_out("postrst", 4'b0010, 8'h00, 8'h00, 1'b1, 16'd0);
    req = '0;
    repeat (2) @(negedge CLK);
    chk_out("postrst_idle", 4'b0, 8'h00, 8'h00, 1'b0, 16'd1);

    // Randomized requesters against the reference model
    RST_n = 1'b0;
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
    model_reset();
    m_bank = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && m_cur == i) begin
          if ($urandom_range(1, 0) == 0) begin
            req[i] = 1'b0;
          end else begin
            op[2*i +: 2]           = 2'($urandom_range(3, 0));
            mask[WIDTH*i +: WIDTH] = 8'($urandom);
          end
        end else if (!req[i] && $urandom_range(2, 0) == 0) begin
          req[i]                 = 1'b1;
          op[2*i +: 2]           = 2'($urandom_range(3, 0));
          mask[WIDTH*i +: WIDTH] = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom);
        end
      end
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      chk_out("rand", (m_cur >= 0) ? 4'(1 << m_cur) : 4'b0000, m_j, m_k, m_busy, m_cnt);
      chk("rand.bank", 32'(bank), 32'(m_bank));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
